led_pattern_seq: RTL and testbench
==================================

Name: led_pattern_seq

Overview:
- Programmable blink-pattern sequencer for a single LED output.
- Holds a small table of (level, duration) segments, written by a host or test controller. On start, plays the segments in order, either once or looping.
- Replaces hard-coded compare chains on a free-running counter. Sits between board glue/host logic and the LED pin.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1_000, duration time base (1 ms ticks).
- NSEG, 8, number of pattern table entries (power of 2, 2..16).
- DUR_W, 16, segment duration width in ticks.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle pulse: begin playback at segment 0.
- Stop  in  1  single-cycle pulse: abort playback.
- Loop  in  1  sampled at Start: 1 = wrap after last segment, 0 = one-shot.
- Num_Seg  in  log2(NSEG)+1  active segment count, sampled at Start.
- Wr_En  in  1  table write strobe.
- Wr_Addr  in  log2(NSEG)  table index.
- Wr_Level  in  1  LED level for the segment.
- Wr_Dur  in  DUR_W  segment duration in ticks.
- LED_Out  out  1  LED drive.
- Busy  out  1  high while in RUN.
- Seg_Idx  out  log2(NSEG)  index of the segment currently playing.
- Done  out  1  one-cycle pulse when a one-shot pattern completes.
- Wr_Err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, table cleared (level 0, dur 0), tick prescaler 0.
- Tick generator: divider of CLK_HZ/TICK_HZ cycles.
  - Cleared on the Start accept cycle.
  - Produces a one-cycle tick every DIV cycles.
- FSM states: IDLE, RUN.
- IDLE -> RUN:
  - Condition: Start=1 and sampled Num_Seg in 1..NSEG.
  - Start is ignored when Num_Seg=0 or Num_Seg>NSEG.
  - Latches Loop and Num_Seg.
  - Cycle after Start: Busy=1, Seg_Idx=0, LED_Out=level[0], duration counter loaded with dur[0].
- RUN:
  - The duration counter decrements on each tick.
  - A segment ends on the tick where the counter = 1.
  - A dur of 0 is treated as 1 tick.
  - Segment k therefore lasts max(dur[k],1)*DIV cycles exactly.
- Segment end:
  - If more segments remain: advance Seg_Idx. LED_Out takes the new level on the next cycle.
  - Last segment with Loop=1: wrap to segment 0, seamlessly with no gap cycle.
  - Last segment with Loop=0: go to IDLE, LED_Out=0, Busy=0, Done=1 for one cycle.
- Stop:
  - Stop in RUN: next cycle IDLE, LED_Out=0, Busy=0, no Done.
  - Stop in IDLE: no effect.
  - Stop and Start in the same cycle: Stop wins.
- Start while in RUN is ignored.
- Table writes:
  - Accepted only in IDLE; the entry is written on the Wr_En cycle.
  - Wr_En in RUN: table unchanged, Wr_Err=1 for one cycle.
  - Wr_En and Start in the same IDLE cycle: the write lands first, and playback uses the new entry.
- Reset mid-playback: immediate return to reset state, table cleared.

Optional Feature:
- Macro: LED_PATTERN_DEFAULT_EN.
- Defined: reset loads table entries 0..4 with a default pattern, and Busy auto-starts in Loop mode with Num_Seg=5 on the first cycle after reset release. The default pattern is:
  - (1,1000)
  - (0,1750)
  - (1,1000)
  - (0,250)
  - (1,1000)
- Not defined: table resets to zeros and the block waits in IDLE for Start.

Decomposition:
- Shared package led_pkg contains:
  - CLK_HZ and TICK_HZ defaults.
  - Derived TICK_DIV.
  - A seg_t typedef {level, dur[DUR_W-1:0]}.
  - FSM state enum.
  - Default pattern constants.
- Sub-module led_tick_gen: prescaler with synchronous clear input and tick output. Reusable by other LED/blink blocks.

Test Plan (bench overrides CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Write entries (1,3),(0,2), Num_Seg=2, Loop=0, Start -> LED_Out=1 for 30 cycles, then 0 for 20 cycles, then Done pulse, Busy=0.
- Same table, Loop=1, run 120 cycles -> LED_Out periodic with period 50 and no gap at wrap; Stop -> LED_Out=0 and Busy=0 next cycle, no Done.
- Entry dur=0 with level 1 -> that segment lasts exactly 10 cycles.
- Wr_En during RUN -> Wr_Err pulse; read back via replay shows table unchanged.
- Start with Num_Seg=0 -> Busy stays 0. Start and Stop in the same cycle -> stays IDLE.
- Assert RSTn low mid-segment, then release -> all outputs 0.
  - With LED_PATTERN_DEFAULT_EN: auto-play with segment lengths 10000,17500,10000,2500,10000 cycles.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer family.
// The LED_PATTERN_DEFAULT_EN build uses the default pattern defined here.
package led_pkg;

  localparam int DEF_CLK_HZ  = 50_000_000;
  localparam int DEF_TICK_HZ = 1_000;
  localparam int TICK_DIV    = DEF_CLK_HZ / DEF_TICK_HZ;
  localparam int DEF_DUR_W   = 16;
  localparam int DEF_NSEG    = 5;

  typedef struct packed {
    logic                 level;
    logic [DEF_DUR_W-1:0] dur;
  } seg_t;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  // Power-on pattern: long-on, long-off, on, short-off, on (in ticks).
  function automatic seg_t def_seg(input int i);
    case (i)
      0:       return {1'b1, 16'd1000};
      1:       return {1'b0, 16'd1750};
      2:       return {1'b1, 16'd1000};
      3:       return {1'b0, 16'd250};
      4:       return {1'b1, 16'd1000};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Time-base prescaler: one-cycle tick every DIV clocks, synchronous clear.
module led_tick_gen #(
  parameter int DIV = led_pkg::TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));
  assign tick = wrap & ~clr;

  // Count 0..DIV-1; clear restarts the phase so the first tick lands DIV cycles later.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || wrap) cnt_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_seq.sv
// Programmable (level, duration) blink sequencer driving one LED.
// Build option LED_PATTERN_DEFAULT_EN: reset preloads a 5-segment pattern
// and playback auto-starts in loop mode right after reset release.
module led_pattern_seq #(
  parameter int CLK_HZ  = led_pkg::DEF_CLK_HZ,
  parameter int TICK_HZ = led_pkg::DEF_TICK_HZ,
  parameter int NSEG    = 8,
  parameter int DUR_W   = led_pkg::DEF_DUR_W,
  localparam int AW     = $clog2(NSEG)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Loop,
  input  logic [AW:0]      Num_Seg,
  input  logic             Wr_En,
  input  logic [AW-1:0]    Wr_Addr,
  input  logic             Wr_Level,
  input  logic [DUR_W-1:0] Wr_Dur,
  output logic             LED_Out,
  output logic             Busy,
  output logic [AW-1:0]    Seg_Idx,
  output logic             Done,
  output logic             Wr_Err
);
  import led_pkg::*;

  localparam int DIV = CLK_HZ / TICK_HZ;

  state_e                   state_q, state_d;
  logic [NSEG-1:0]          lvl_q, lvl_d;
  logic [NSEG-1:0][DUR_W-1:0] dur_q, dur_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [AW:0]              nseg_q, nseg_d;
  logic [DUR_W-1:0]         cnt_q, cnt_d;
  logic                     loop_q, loop_d;
  logic                     led_q, led_d;
  logic                     done_q, done_d;
  logic                     werr_q, werr_d;

  logic                     go_req, go_loop, go, wr_ok, tick, seg_end, last;
  logic [AW:0]              go_n;
  logic                     first_lvl;
  logic [DUR_W-1:0]         first_dur;
  logic [AW-1:0]            nxt_idx;

`ifdef LED_PATTERN_DEFAULT_EN
  localparam bit RST_DEF = 1'b1;
  logic auto_q, auto_d;
  assign auto_d  = 1'b0;
  assign go_req  = Start | auto_q;
  assign go_loop = Loop | auto_q;
  assign go_n    = auto_q ? (AW+1)'(DEF_NSEG) : Num_Seg;
  // One-shot auto-start request, armed by reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) auto_q <= 1'b1;
    else       auto_q <= auto_d;
  end
`else
  localparam bit RST_DEF = 1'b0;
  assign go_req  = Start;
  assign go_loop = Loop;
  assign go_n    = Num_Seg;
`endif

  function automatic seg_t rst_seg(input int i);
    return (RST_DEF && i < DEF_NSEG) ? def_seg(i) : '0;
  endfunction

  led_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (CLK),
    .rst_n(RSTn),
    .clr  (go),
    .tick (tick)
  );

  assign wr_ok     = Wr_En && (state_q == S_IDLE);
  assign go        = (state_q == S_IDLE) && go_req && !Stop &&
                     (go_n != '0) && (go_n <= (AW+1)'(NSEG));
  // A same-cycle write to entry 0 must be visible to the segment being loaded.
  assign first_lvl = (wr_ok && Wr_Addr == '0) ? Wr_Level : lvl_q[0];
  assign first_dur = (wr_ok && Wr_Addr == '0) ? Wr_Dur   : dur_q[0];
  // Counter value 0 or 1 both end the segment, so dur=0 plays as one tick.
  assign seg_end   = tick && (cnt_q <= DUR_W'(1));
  assign last      = ({1'b0, idx_q} + 1'b1) == nseg_q;
  assign nxt_idx   = last ? '0 : idx_q + 1'b1;

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: Stop dominates; one-shot ends after the last segment.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_RUN;
      S_RUN: begin
        if (Stop)                              state_d = S_IDLE;
        else if (seg_end && last && !loop_q)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Playback datapath and registered outputs.
  always_comb begin
    idx_d  = idx_q;
    nseg_d = nseg_q;
    loop_d = loop_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    done_d = 1'b0;
    werr_d = Wr_En && (state_q == S_RUN);
    case (state_q)
      S_IDLE: begin
        if (go) begin
          idx_d  = '0;
          nseg_d = go_n;
          loop_d = go_loop;
          cnt_d  = first_dur;
          led_d  = first_lvl;
        end
      end
      S_RUN: begin
        if (Stop) begin
          led_d = 1'b0;
          idx_d = '0;
        end else if (seg_end) begin
          if (last && !loop_q) begin
            led_d  = 1'b0;
            idx_d  = '0;
            done_d = 1'b1;
          end else begin
            idx_d = nxt_idx;
            cnt_d = dur_q[nxt_idx];
            led_d = lvl_q[nxt_idx];
          end
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Table write path: only accepted while idle.
  always_comb begin
    lvl_d = lvl_q;
    dur_d = dur_q;
    if (wr_ok) begin
      lvl_d[Wr_Addr] = Wr_Level;
      dur_d[Wr_Addr] = Wr_Dur;
    end
  end

  // Datapath and table registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      idx_q  <= '0;
      nseg_q <= '0;
      loop_q <= 1'b0;
      cnt_q  <= '0;
      led_q  <= 1'b0;
      done_q <= 1'b0;
      werr_q <= 1'b0;
      for (int i = 0; i < NSEG; i++) begin
        lvl_q[i] <= rst_seg(i).level;
        dur_q[i] <= DUR_W'(rst_seg(i).dur);
      end
    end else begin
      idx_q  <= idx_d;
      nseg_q <= nseg_d;
      loop_q <= loop_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      done_q <= done_d;
      werr_q <= werr_d;
      lvl_q  <= lvl_d;
      dur_q  <= dur_d;
    end
  end

  assign LED_Out = led_q;
  assign Busy    = (state_q == S_RUN);
  assign Seg_Idx = idx_q;
  assign Done    = done_q;
  assign Wr_Err  = werr_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with CLK_HZ=1000, TICK_HZ=100 (10-cycle ticks).
module tb_led_pattern_seq;
  localparam int NSEG  = 8;
  localparam int AW    = 3;
  localparam int DUR_W = 16;

  logic             CLK = 1'b0;
  logic             RSTn, Start, Stop, Loop, Wr_En, Wr_Level;
  logic [AW:0]      Num_Seg;
  logic [AW-1:0]    Wr_Addr;
  logic [DUR_W-1:0] Wr_Dur;
  logic             LED_Out, Busy, Done, Wr_Err;
  logic [AW-1:0]    Seg_Idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  led_pattern_seq #(.CLK_HZ(1000), .TICK_HZ(100), .NSEG(NSEG), .DUR_W(DUR_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .Start(Start), .Stop(Stop), .Loop(Loop),
    .Num_Seg(Num_Seg), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Level(Wr_Level),
    .Wr_Dur(Wr_Dur), .LED_Out(LED_Out), .Busy(Busy), .Seg_Idx(Seg_Idx),
    .Done(Done), .Wr_Err(Wr_Err)
  );

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wr(input int a, input logic l, input int d);
    Wr_En = 1'b1; Wr_Addr = AW'(a); Wr_Level = l; Wr_Dur = DUR_W'(d);
    step();
    Wr_En = 1'b0;
  endtask

  task automatic go(input int n, input logic lp);
    Start = 1'b1; Num_Seg = (AW+1)'(n); Loop = lp;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_tests++;
    if ({LED_Out, Busy, Seg_Idx, Done, Wr_Err} !== 7'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000000", {LED_Out, Busy, Seg_Idx, Done, Wr_Err});
    end
    @(posedge CLK); #1; RSTn = 1'b1;
`ifndef LED_PATTERN_DEFAULT_EN
    step(3);
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b expected 0", Busy); end
`endif
  endtask

`ifdef LED_PATTERN_DEFAULT_EN
  task automatic test_default;
    int len [5];
    int c;
    step();
    n_tests++;
    if (Busy !== 1'b1 || LED_Out !== 1'b1) begin
      n_fail++; $display("FAIL auto_start: busy=%b led=%b expected 1 1", Busy, LED_Out);
    end
    for (int s = 0; s < 5; s++) begin
      c = 0;
      while (Seg_Idx == AW'(s) && c < 20000) begin c++; step(); end
      len[s] = c;
    end
    n_tests++;
    if (len[0] !== 10000 || len[1] !== 17500 || len[2] !== 10000 || len[3] !== 2500 || len[4] !== 10000) begin
      n_fail++; $display("FAIL default_lengths: got %0d %0d %0d %0d %0d expected 10000 17500 10000 2500 10000",
                         len[0], len[1], len[2], len[3], len[4]);
    end
    Stop = 1'b1; step(); Stop = 1'b0;
  endtask
`endif

  task automatic test_oneshot;
    int hi, lo, bi;
    wr(0, 1'b1, 3); wr(1, 1'b0, 2);
    go(2, 1'b0);
    hi = 0; lo = 0; bi = 0;
    for (int c = 1; c <= 30; c++) begin if (LED_Out === 1'b1 && Busy === 1'b1) hi++; step(); end
    for (int c = 31; c <= 50; c++) begin
      if (LED_Out === 1'b0 && Busy === 1'b1) lo++;
      if (Seg_Idx === 3'd1) bi++;
      step();
    end
    n_tests++;
    if (hi !== 30) begin n_fail++; $display("FAIL oneshot_high: got %0d cycles expected 30", hi); end
    n_tests++;
    if (lo !== 20 || bi !== 20) begin n_fail++; $display("FAIL oneshot_low: got %0d/%0d cycles expected 20/20", lo, bi); end
    n_tests++;
    if (Done !== 1'b1 || Busy !== 1'b0 || LED_Out !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_done: done=%b busy=%b led=%b expected 1 0 0", Done, Busy, LED_Out);
    end
    step();
    n_tests++;
    if (Done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: done=%b expected 0", Done); end
  endtask

  task automatic test_loop;
    int bad, dn;
    logic exp;
    go(2, 1'b1);
    bad = 0; dn = 0;
    for (int c = 1; c <= 120; c++) begin
      exp = (((c - 1) % 50) < 30);
      if (LED_Out !== exp || Busy !== 1'b1) bad++;
      if (Done === 1'b1) dn++;
      step();
    end
    n_tests++;
    if (bad !== 0 || dn !== 0) begin n_fail++; $display("FAIL loop_wave: bad=%0d done=%0d expected 0 0", bad, dn); end
    Stop = 1'b1; step(); Stop = 1'b0;
    n_tests++;
    if (LED_Out !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL stop: led=%b busy=%b done=%b expected 0 0 0", LED_Out, Busy, Done);
    end
  endtask

  task automatic test_dur_zero;
    int hi, dc;
    wr(0, 1'b1, 0); wr(1, 1'b0, 1);
    go(2, 1'b0);
    hi = 0; dc = 0;
    for (int c = 1; c <= 25; c++) begin
      if (LED_Out === 1'b1) hi++;
      if (Done === 1'b1 && dc == 0) dc = c;
      step();
    end
    n_tests++;
    if (hi !== 10 || dc !== 21) begin n_fail++; $display("FAIL dur_zero: high=%0d done_at=%0d expected 10 21", hi, dc); end
  endtask

  task automatic test_wr_in_run;
    int hi;
    go(2, 1'b1);
    step(3);
    wr(0, 1'b0, 5);
    n_tests++;
    if (Wr_Err !== 1'b1) begin n_fail++; $display("FAIL wr_err_run: got %b expected 1", Wr_Err); end
    step();
    n_tests++;
    if (Wr_Err !== 1'b0) begin n_fail++; $display("FAIL wr_err_pulse: got %b expected 0", Wr_Err); end
    Stop = 1'b1; step(); Stop = 1'b0;
    go(2, 1'b0);
    hi = 0;
    for (int c = 1; c <= 25; c++) begin if (LED_Out === 1'b1) hi++; step(); end
    n_tests++;
    if (hi !== 10) begin n_fail++; $display("FAIL table_unchanged: high=%0d expected 10", hi); end
    wr(3, 1'b1, 1);
    n_tests++;
    if (Wr_Err !== 1'b0) begin n_fail++; $display("FAIL wr_err_idle: got %b expected 0", Wr_Err); end
  endtask

  task automatic test_start_ignore;
    go(0, 1'b0);
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL nseg_zero: busy=%b expected 0", Busy); end
    go(9, 1'b0);
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL nseg_over: busy=%b expected 0", Busy); end
    Stop = 1'b1; go(2, 1'b0); Stop = 1'b0;
    step();
    n_tests++;
    if (Busy !== 1'b0 || LED_Out !== 1'b0) begin
      n_fail++; $display("FAIL start_stop: busy=%b led=%b expected 0 0", Busy, LED_Out);
    end
  endtask

  task automatic test_wr_start_same;
    int hi, dc;
    Wr_En = 1'b1; Wr_Addr = '0; Wr_Level = 1'b1; Wr_Dur = 16'd2;
    go(1, 1'b0);
    Wr_En = 1'b0;
    hi = 0; dc = 0;
    for (int c = 1; c <= 25; c++) begin
      if (LED_Out === 1'b1) hi++;
      if (Done === 1'b1 && dc == 0) dc = c;
      step();
    end
    n_tests++;
    if (hi !== 20 || dc !== 21) begin n_fail++; $display("FAIL wr_start_same: high=%0d done_at=%0d expected 20 21", hi, dc); end
  endtask

  task automatic test_reset_mid;
    go(2, 1'b1);
    step(5);
    RSTn = 1'b0;
    #2;
    n_tests++;
    if ({LED_Out, Busy, Seg_Idx, Done, Wr_Err} !== 7'd0) begin
      n_fail++; $display("FAIL reset_mid: got %b expected 0000000", {LED_Out, Busy, Seg_Idx, Done, Wr_Err});
    end
    step(2);
    RSTn = 1'b1;
`ifndef LED_PATTERN_DEFAULT_EN
    begin
      int hi, dc;
      step();
      n_tests++;
      if ({LED_Out, Busy, Seg_Idx, Done, Wr_Err} !== 7'd0) begin
        n_fail++; $display("FAIL after_release: got %b expected 0000000", {LED_Out, Busy, Seg_Idx, Done, Wr_Err});
      end
      go(2, 1'b0);
      hi = 0; dc = 0;
      for (int c = 1; c <= 25; c++) begin
        if (LED_Out === 1'b1) hi++;
        if (Done === 1'b1 && dc == 0) dc = c;
        step();
      end
      n_tests++;
      if (hi !== 0 || dc !== 21) begin n_fail++; $display("FAIL table_cleared: high=%0d done_at=%0d expected 0 21", hi, dc); end
    end
`endif
  endtask

  initial begin
    RSTn = 1'b0; Start = 1'b0; Stop = 1'b0; Loop = 1'b0; Num_Seg = '0;
    Wr_En = 1'b0; Wr_Addr = '0; Wr_Level = 1'b0; Wr_Dur = '0;
    test_reset();
`ifdef LED_PATTERN_DEFAULT_EN
    test_default();
`endif
    test_oneshot();
    test_loop();
    test_dur_zero();
    test_wr_in_run();
    test_start_ignore();
    test_wr_start_same();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
